id_branch: RTL and testbench
============================

# id_branch

Decode-side end of the fetch interface. Holds the IF/ID pipeline register for the instruction word and its PC+4 coming out of fetch. Resolves MIPS control-flow instructions (beq, bne, j, jal, jr, jalr) in the ID stage. Drives `targ_addr` and `PC_sel` back to the fetch stage's next-PC mux, and manages delay-slot or squash sequencing and stall hold.

## Interface
Parameters:
- `DELAY_SLOT`, 1: 1 = the instruction after a taken branch executes (architectural MIPS); 0 = it is squashed.
- `CNT_W`, 32: width of the branch and taken-branch performance counters.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction word from fetch.
- `pc_plus4`  in  32  PC+4 of `instr`, from fetch.
- `stall`  in  1  hazard-unit hold request.
- `rs_data`  in  32  register-file read of `id_instr[25:21]`.
- `rt_data`  in  32  register-file read of `id_instr[20:16]`.
- `targ_addr`  out  32  redirect target for fetch.
- `PC_sel`  out  1  1 = fetch loads `targ_addr` at the next edge.
- `if_hold`  out  1  fetch must hold its PC this cycle.
- `id_instr`  out  32  registered instruction.
- `id_pcplus4`  out  32  registered PC+4.
- `id_valid`  out  1  `id_instr` is live; 0 = bubble.
- `rs_addr`  out  5  `id_instr[25:21]`.
- `rt_addr`  out  5  `id_instr[20:16]`.
- `br_cnt`  out  `CNT_W`  control-flow instructions resolved.
- `taken_cnt`  out  `CNT_W`  redirects issued.

## Operation
- **IF/ID register.** When `stall=0`, capture `instr` and `pc_plus4` at each edge. When `stall=1`, hold both.
- **Valid bit.** `id_valid` is set to 1 on capture, except it is set to 0 when the next state is SQUASH.
- **Decode** uses registered `id_instr` only:
  - beq: op 6'b000100.
  - bne: op 6'b000101.
  - j: op 6'b000010.
  - jal: op 6'b000011.
  - jr: op 0, funct 6'b001000.
  - jalr: op 0, funct 6'b001001.
- **Targets:**
  - beq/bne: `id_pcplus4 + {{14{imm[15]}}, imm, 2'b00}`, mod 2^32; wrap-around is not flagged.
  - j/jal: `{id_pcplus4[31:28], id_instr[25:0], 2'b00}`.
  - jr/jalr: `rs_data`.
- **Taken condition:**
  - beq: `rs_data == rt_data`.
  - bne: `rs_data != rt_data`.
  - Jumps: always taken.
- **Redirect.** `PC_sel = valid & taken & ~stall & (state != SLOT)`. `targ_addr` is 0 whenever `PC_sel=0`.
- **`if_hold`** equals `stall`.
- **FSM states:** RUN, SLOT, SQUASH.
  - RUN: on `PC_sel`, go to SLOT if `DELAY_SLOT=1`, else SQUASH. Otherwise stay in RUN.
  - SLOT: the ID instruction is the delay slot. It executes, but its own branch never redirects (`PC_sel` forced to 0) and is not counted. Go to RUN on the next non-stalled edge.
  - SQUASH: `id_valid=0` and nothing decodes. Go to RUN on the next non-stalled edge.
  - While `stall=1`, the state is held.
- **Counters:**
  - `br_cnt` increments on each non-stalled edge where a valid control-flow instruction is decoded outside SLOT.
  - `taken_cnt` increments on each edge where `PC_sel=1`.
  - Both wrap modulo 2^`CNT_W`.

## Timing
- **Reset values:** `id_instr`=0 (NOP), `id_pcplus4`=0, `id_valid`=0, state RUN, `PC_sel`=0, `targ_addr`=0, `if_hold`=0, counters 0.
- **Reset wins.** `rst` overrides `stall` and any pending redirect. Reset in SLOT or SQUASH returns to RUN at that edge.
- **Capture latency:** one cycle from `instr` to `id_instr`.
- **Redirect latency:** `PC_sel` and `targ_addr` are combinational from registered state and `rs_data`/`rt_data`, valid in the same cycle the branch sits in ID. Fetch applies the redirect at the end of that cycle. The IF-stage word captured at that edge is the delay slot.
- **Stall and branch together:** stall wins. `PC_sel=0`, and the redirect is re-evaluated on the first cycle with `stall=0`. No counter increments while stalled.
- **Back-to-back branches:**
  - `DELAY_SLOT=1`: a branch in the slot is ignored.
  - `DELAY_SLOT=0`: it is squashed, so it never resolves.
- **jr/jalr** use the current-cycle `rs_data`. Forwarding is external; the hazard unit asserts `stall` until `rs_data` is correct.

## Structure
- Shared package `mips_pkg`: opcode and funct constants (OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR, FN_JALR), the FSM state enum, and the NOP encoding.
- One sub-module, `br_target`: combinational decode, target, and taken computation from `id_instr`, `id_pcplus4`, `rs_data` and `rt_data`.
- The top level holds the IF/ID registers, FSM and counters.

## Test plan
- **Reset mid-SLOT:** assert `rst` while in SLOT with `stall=0` → next cycle all outputs are at reset values, state RUN, counters 0.
- **beq taken:** `id_pcplus4`=0x0040_0010, imm=0xFFFE, rs=rt=5 → `PC_sel=1`, `targ_addr`=0x0040_0008. Delay slot valid (`DELAY_SLOT=1`), or `id_valid=0` next cycle (`DELAY_SLOT=0`). `taken_cnt`=1.
- **bne not taken:** rs=rt=7 → `PC_sel=0`, `targ_addr`=0, `br_cnt`=1, `taken_cnt`=0.
- **j and jr:**
  - j with `id_pcplus4`=0xA000_0004, index 0x0000100 → `targ_addr`=0xA000_0400.
  - jr with `rs_data`=0x1234_5678 → `targ_addr`=0x1234_5678.
- **Stall over a taken branch:** `stall=1` for 3 cycles → `PC_sel=0`, `if_hold=1`, and `id_instr`, state and counters frozen. On release, `PC_sel=1` for exactly one cycle.
- **Branch in delay slot:** beq followed by a taken bne (`DELAY_SLOT=1`) → only the first redirects. `taken_cnt`=1, `br_cnt`=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control-flow encodings and the ID-stage branch FSM state type.
package mips_pkg;
  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam logic [5:0]  OP_BNE     = 6'b000101;
  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_JAL     = 6'b000011;
  localparam logic [5:0]  FN_JR      = 6'b001000;
  localparam logic [5:0]  FN_JALR    = 6'b001001;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {ST_RUN, ST_SLOT, ST_SQUASH} br_state_t;
endpackage

// File: rtl/br_target.sv
// Combinational control-flow decode: classifies the ID word, computes its target and taken flag.
module br_target
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pcplus4,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_is_cf,
  output logic        o_taken,
  output logic [31:0] o_targ
);
  logic [5:0]  w_op, w_fn;
  logic [31:0] w_br_off;

  assign w_op     = i_instr[31:26];
  assign w_fn     = i_instr[5:0];
  assign w_br_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

  always_comb begin
    o_is_cf = 1'b0;
    o_taken = 1'b0;
    o_targ  = 32'h0;
    case (w_op)
      OP_BEQ: begin
        o_is_cf = 1'b1;
        o_taken = (i_rs_data == i_rt_data);
        o_targ  = i_pcplus4 + w_br_off;
      end
      OP_BNE: begin
        o_is_cf = 1'b1;
        o_taken = (i_rs_data != i_rt_data);
        o_targ  = i_pcplus4 + w_br_off;
      end
      OP_J, OP_JAL: begin
        o_is_cf = 1'b1;
        o_taken = 1'b1;
        o_targ  = {i_pcplus4[31:28], i_instr[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        if (w_fn == FN_JR || w_fn == FN_JALR) begin
          o_is_cf = 1'b1;
          o_taken = 1'b1;
          o_targ  = i_rs_data;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_branch.sv
// IF/ID register plus ID-stage branch resolution, redirect to fetch, and slot/squash sequencing.
module id_branch
  import mips_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc_plus4,
  input  logic             stall,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [31:0]      targ_addr,
  output logic             PC_sel,
  output logic             if_hold,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pcplus4,
  output logic             id_valid,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  br_state_t        r_state, w_nstate;
  logic [31:0]      r_instr, r_pcplus4;
  logic             r_valid;
  logic [CNT_W-1:0] r_br_cnt, r_taken_cnt;
  logic             w_is_cf, w_taken, w_pc_sel, w_br_inc;
  logic [31:0]      w_targ;

  br_target u_br_target (
    .i_instr   (r_instr),
    .i_pcplus4 (r_pcplus4),
    .i_rs_data (rs_data),
    .i_rt_data (rt_data),
    .o_is_cf   (w_is_cf),
    .o_taken   (w_taken),
    .o_targ    (w_targ)
  );

  // A branch sitting in the delay slot never redirects; SQUASH is covered by r_valid=0.
  always_comb begin
    w_pc_sel = r_valid & w_taken & ~stall & (r_state != ST_SLOT);
    w_br_inc = r_valid & w_is_cf & ~stall & (r_state != ST_SLOT);
    w_nstate = r_state;
    if (!stall) begin
      case (r_state)
        ST_RUN:  if (w_pc_sel) w_nstate = (DELAY_SLOT != 0) ? ST_SLOT : ST_SQUASH;
        default: w_nstate = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_instr     <= NOP;
      r_pcplus4   <= 32'h0;
      r_valid     <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state <= w_nstate;
      if (!stall) begin
        r_instr   <= instr;
        r_pcplus4 <= pc_plus4;
        r_valid   <= (w_nstate != ST_SQUASH);
      end
      if (w_br_inc) r_br_cnt    <= r_br_cnt + CNT_W'(1);
      if (w_pc_sel) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign PC_sel     = w_pc_sel;
  assign targ_addr  = w_pc_sel ? w_targ : 32'h0;
  assign if_hold    = stall;
  assign id_instr   = r_instr;
  assign id_pcplus4 = r_pcplus4;
  assign id_valid   = r_valid;
  assign rs_addr    = r_instr[25:21];
  assign rt_addr    = r_instr[20:16];
  assign br_cnt     = r_br_cnt;
  assign taken_cnt  = r_taken_cnt;
endmodule

// File: tb/tb_id_branch.sv
// Directed-vector bench for id_branch: one delay-slot instance and one squash instance on shared stimulus.
module tb_id_branch;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] instr, pc_plus4, rs_data, rt_data;

  logic [31:0] a_targ, b_targ, a_iid, b_iid, a_ipc, b_ipc, a_br, b_br, a_tk, b_tk;
  logic        a_sel, b_sel, a_hold, b_hold, a_val, b_val;
  logic [4:0]  a_rs, b_rs, a_rt, b_rt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_BEQ  = 32'h1022_FFFE; // beq r1,r2,-2
  localparam logic [31:0] I_BNE  = 32'h1422_0004; // bne r1,r2,+4
  localparam logic [31:0] I_J    = 32'h0800_0100;
  localparam logic [31:0] I_JR   = 32'h0020_0008; // jr r1
  localparam logic [31:0] I_ADDI = 32'h2001_0001;

  always #5 clk = ~clk;

  id_branch #(.DELAY_SLOT(1), .CNT_W(32)) u_ds1 (
    .clk(clk), .rst(rst), .instr(instr), .pc_plus4(pc_plus4), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .targ_addr(a_targ), .PC_sel(a_sel),
    .if_hold(a_hold), .id_instr(a_iid), .id_pcplus4(a_ipc), .id_valid(a_val),
    .rs_addr(a_rs), .rt_addr(a_rt), .br_cnt(a_br), .taken_cnt(a_tk)
  );

  id_branch #(.DELAY_SLOT(0), .CNT_W(32)) u_ds0 (
    .clk(clk), .rst(rst), .instr(instr), .pc_plus4(pc_plus4), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .targ_addr(b_targ), .PC_sel(b_sel),
    .if_hold(b_hold), .id_instr(b_iid), .id_pcplus4(b_ipc), .id_valid(b_val),
    .rs_addr(b_rs), .rt_addr(b_rt), .br_cnt(b_br), .taken_cnt(b_tk)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, settle.
  task automatic tick(input logic [31:0] w, input logic [31:0] pc);
    instr = w; pc_plus4 = pc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0;
    tick(32'h0, 32'h0);
    tick(32'h0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " a_iid"},  a_iid, 32'h0);
    chk({tag, " a_ipc"},  a_ipc, 32'h0);
    chk({tag, " a_val"},  {31'h0, a_val}, 32'h0);
    chk({tag, " a_sel"},  {31'h0, a_sel}, 32'h0);
    chk({tag, " a_targ"}, a_targ, 32'h0);
    chk({tag, " a_hold"}, {31'h0, a_hold}, 32'h0);
    chk({tag, " a_br"},   a_br, 32'h0);
    chk({tag, " a_tk"},   a_tk, 32'h0);
    chk({tag, " b_iid"},  b_iid, 32'h0);
    chk({tag, " b_val"},  {31'h0, b_val}, 32'h0);
    chk({tag, " b_sel"},  {31'h0, b_sel}, 32'h0);
    chk({tag, " b_br"},   b_br, 32'h0);
    chk({tag, " b_tk"},   b_tk, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr = 32'h0; pc_plus4 = 32'h0;
    rs_data = 32'h0; rt_data = 32'h0;

    // Reset state
    do_reset();
    chk_reset("rst");

    // beq taken, then reset while ds1 sits in SLOT / ds0 in SQUASH
    rs_data = 32'd5; rt_data = 32'd5;
    tick(I_BEQ, 32'h0040_0010);
    chk("beq a_sel",  {31'h0, a_sel}, 32'h1);
    chk("beq a_targ", a_targ, 32'h0040_0008);
    chk("beq b_sel",  {31'h0, b_sel}, 32'h1);
    chk("beq b_targ", b_targ, 32'h0040_0008);
    chk("beq rs_addr", {27'h0, a_rs}, 32'd1);
    chk("beq rt_addr", {27'h0, a_rt}, 32'd2);
    tick(I_ADDI, 32'h0040_0014);
    chk("slot a_val", {31'h0, a_val}, 32'h1);
    chk("slot a_iid", a_iid, I_ADDI);
    chk("sq b_val",   {31'h0, b_val}, 32'h0);
    chk("slot a_tk",  a_tk, 32'd1);
    chk("slot a_br",  a_br, 32'd1);
    chk("sq b_tk",    b_tk, 32'd1);
    rst = 1'b1;
    tick(I_BEQ, 32'h0040_0018);
    chk_reset("rstslot");
    rst = 1'b0;

    // bne not taken
    rs_data = 32'd7; rt_data = 32'd7;
    tick(I_BNE, 32'h0000_1000);
    chk("bne a_sel",  {31'h0, a_sel}, 32'h0);
    chk("bne a_targ", a_targ, 32'h0);
    chk("bne b_sel",  {31'h0, b_sel}, 32'h0);
    tick(32'h0, 32'h0000_1004);
    chk("bne a_br", a_br, 32'd1);
    chk("bne a_tk", a_tk, 32'd0);
    chk("bne b_br", b_br, 32'd1);

    // j and jr
    tick(I_J, 32'hA000_0004);
    chk("j a_targ", a_targ, 32'hA000_0400);
    chk("j b_targ", b_targ, 32'hA000_0400);
    tick(32'h0, 32'hA000_0008);
    tick(32'h0, 32'h0000_0404);
    rs_data = 32'h1234_5678;
    tick(I_JR, 32'h0000_0408);
    chk("jr a_sel",  {31'h0, a_sel}, 32'h1);
    chk("jr a_targ", a_targ, 32'h1234_5678);
    chk("jr b_targ", b_targ, 32'h1234_5678);
    tick(32'h0, 32'h0000_040C);
    tick(32'h0, 32'h1234_567C);
    chk("jj a_br", a_br, 32'd3);
    chk("jj a_tk", a_tk, 32'd2);
    chk("jj b_br", b_br, 32'd3);
    chk("jj b_tk", b_tk, 32'd2);

    // Stall over a taken branch
    do_reset();
    rs_data = 32'd5; rt_data = 32'd5;
    tick(I_BEQ, 32'h0040_0010);
    stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stl a_sel",  {31'h0, a_sel}, 32'h0);
      chk("stl a_hold", {31'h0, a_hold}, 32'h1);
      chk("stl a_targ", a_targ, 32'h0);
      tick(32'hDEAD_BEEF, 32'h0040_0014);
      chk("stl a_iid", a_iid, I_BEQ);
      chk("stl a_br",  a_br, 32'd0);
      chk("stl a_tk",  a_tk, 32'd0);
      chk("stl b_tk",  b_tk, 32'd0);
    end
    stall = 1'b0; #1;
    chk("rel a_sel",  {31'h0, a_sel}, 32'h1);
    chk("rel a_hold", {31'h0, a_hold}, 32'h0);
    chk("rel a_targ", a_targ, 32'h0040_0008);
    tick(32'h0, 32'h0040_0014);
    chk("rel1 a_sel", {31'h0, a_sel}, 32'h0);
    chk("rel1 a_tk",  a_tk, 32'd1);
    chk("rel1 a_br",  a_br, 32'd1);
    chk("rel1 a_val", {31'h0, a_val}, 32'h1);
    chk("rel1 b_val", {31'h0, b_val}, 32'h0);
    chk("rel1 b_tk",  b_tk, 32'd1);

    // Branch in the delay slot
    do_reset();
    rs_data = 32'd5; rt_data = 32'd5;
    tick(I_BEQ, 32'h0040_0010);
    chk("bb a_sel0", {31'h0, a_sel}, 32'h1);
    tick(I_BNE, 32'h0040_0014);
    rt_data = 32'd6; #1;
    chk("bb a_sel1", {31'h0, a_sel}, 32'h0);
    chk("bb a_targ", a_targ, 32'h0);
    chk("bb a_val",  {31'h0, a_val}, 32'h1);
    chk("bb b_sel1", {31'h0, b_sel}, 32'h0);
    chk("bb b_val",  {31'h0, b_val}, 32'h0);
    tick(32'h0, 32'h0040_0008);
    chk("bb a_tk", a_tk, 32'd1);
    chk("bb a_br", a_br, 32'd1);
    chk("bb b_tk", b_tk, 32'd1);
    chk("bb b_br", b_br, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
